// File: rtl/pmem_slave.sv
// Latency-modelled doubleword memory slave: one request at a time over valid/ready,
// response (load data or store ack) presented after LATENCY cycles and held until taken.
module pmem_slave #(
  parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_8000_0000,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [63:0] SPAN  = 64'd8 << DEPTH_LOG2;
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  if (LATENCY == 0) begin : g_latency_check
    $error("pmem_slave: LATENCY must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic                   wr_q, ok_q;
  logic [DEPTH_LOG2-1:0]  idx_q;
  logic [63:0]            wdata_q;
  logic [7:0]             wmask_q;
  logic [63:0]            mem [DEPTH];

  logic [63:0]            off;
  logic                   req_ok, accept, enter_resp;
  logic [DEPTH_LOG2-1:0]  req_idx;
  logic                   acc_wr, acc_ok;
  logic [DEPTH_LOG2-1:0]  acc_idx;
  logic [63:0]            acc_wdata;
  logic [7:0]             acc_wmask;

  // Range check via the offset avoids overflow of BASE_ADDR + span.
  assign off     = req_addr - BASE_ADDR;
  assign req_ok  = (req_addr >= BASE_ADDR) && (off < SPAN);
  assign req_idx = off[DEPTH_LOG2+2:3];

  assign req_ready  = (state == IDLE) && !rst;
  assign resp_valid = (state == RESP);
  assign accept     = req_valid && req_ready;

  // With LATENCY==1 RESP is entered on the accept edge, so the live request is used.
  assign acc_wr    = (state == IDLE) ? req_write : wr_q;
  assign acc_ok    = (state == IDLE) ? req_ok    : ok_q;
  assign acc_idx   = (state == IDLE) ? req_idx   : idx_q;
  assign acc_wdata = (state == IDLE) ? req_wdata : wdata_q;
  assign acc_wmask = (state == IDLE) ? req_wmask : wmask_q;

  assign enter_resp = !rst && (state != RESP) && (state_nxt == RESP);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = (LATENCY == 1) ? RESP : WAIT;
      WAIT: if (cnt == '0) state_nxt = RESP;
      RESP: if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        wr_q    <= req_write;
        ok_q    <= req_ok;
        idx_q   <= req_idx;
        wdata_q <= req_wdata;
        wmask_q <= req_wmask;
        cnt     <= CNT_W'(LATENCY - 2);
      end else if (state == WAIT) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (enter_resp) begin
        resp_err   <= !acc_ok;
        resp_rdata <= (acc_ok && !acc_wr) ? mem[acc_idx] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enter_resp && acc_ok && acc_wr) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (acc_wmask[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

endmodule
